// File: rtl/gat_bram_loader.sv
// ---------------------------------------------------------------------------
// gat_bram_loader
//
// Upstream load stage for one GAT accelerator input BRAM (H data, H node-info
// or weight). A start pulse arms a load of `len` words; the loader then takes
// 32-bit words from a valid/ready stream and writes them one per cycle to BRAM
// port A at consecutive word addresses (byte address = word index * 4). When
// the final word has been written, load_done rises and stays high until the
// next accepted start. A length/tlast disagreement or an oversize request sets
// the sticky err_len flag.
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   start, len      - one-cycle load request and word count (sampled on accept)
//   s_tdata/s_tvalid/s_tready/s_tlast - input word stream
//   bram_din/bram_ena/bram_wea/bram_addra - BRAM port A write interface
//   load_done       - level, all words of the load written
//   busy            - high while loading or flushing the final write
//   err_len         - sticky length/tlast mismatch or oversize request
//   words_loaded    - words written in the current or last load
// ---------------------------------------------------------------------------
module gat_bram_loader #(
  parameter int DEPTH  = 242101,
  parameter int ADDR_W = $clog2(DEPTH) + 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [31:0]       s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  output logic [31:0]       bram_din,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic              load_done,
  output logic              busy,
  output logic              err_len,
  output logic [CNT_W-1:0]  words_loaded
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   words_loaded_q, words_loaded_d;
  logic [31:0]        bram_din_q, bram_din_d;
  logic [ADDR_W-1:0]  bram_addra_q, bram_addra_d;
  logic               bram_en_q, bram_en_d;
  logic               load_done_q, load_done_d;
  logic               err_len_q, err_len_d;

  logic [CNT_W-1:0]   last_idx;
  logic [CNT_W+1:0]   wr_byte_addr;
  logic               beat;
  logic               count_hit;
  logic               oversize;

  // Ready depends only on the state so the stream never sees a bubble
  // inside LOAD; it drops the cycle after the final beat.
  assign s_tready = (state_q == ST_LOAD);
  assign beat     = s_tready && s_tvalid;

  // len_q is at least 1 whenever LOAD is entered, so last_idx never wraps
  // in a state where it is used.
  assign last_idx     = len_q - CNT_W'(1);
  assign count_hit    = (cnt_q == last_idx);
  assign oversize     = (len > DEPTH_C);
  assign wr_byte_addr = {cnt_q, 2'b00};

  // Next-state and next-output logic. Write strobes default low every cycle;
  // data/address hold so the BRAM port shows the last written location.
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    words_loaded_d = words_loaded_q;
    bram_din_d     = bram_din_q;
    bram_addra_d   = bram_addra_q;
    bram_en_d      = 1'b0;
    load_done_d    = load_done_q;
    err_len_d      = err_len_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Clamp to the BRAM size so the address can never wrap.
          len_d          = oversize ? DEPTH_C : len;
          err_len_d      = oversize;
          load_done_d    = 1'b0;
          words_loaded_d = '0;
          cnt_d          = '0;
          state_d        = (len == '0) ? ST_DONE : ST_LOAD;
        end else if (state_q == ST_DONE) begin
          // Covers the zero-length case, where DONE is entered with
          // load_done still low.
          load_done_d = 1'b1;
        end
      end

      ST_LOAD: begin
        if (beat) begin
          bram_en_d      = 1'b1;
          bram_din_d     = s_tdata;
          bram_addra_d   = wr_byte_addr[ADDR_W-1:0];
          cnt_d          = cnt_q + CNT_W'(1);
          words_loaded_d = cnt_q + CNT_W'(1);
          // The final beat is either the counted last word or any tlast;
          // disagreement between the two is a length error.
          if (count_hit || s_tlast) begin
            state_d   = ST_FLUSH;
            err_len_d = err_len_q | (count_hit != s_tlast);
          end
        end
      end

      ST_FLUSH: begin
        state_d     = ST_DONE;
        load_done_d = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      cnt_q          <= '0;
      words_loaded_q <= '0;
      bram_din_q     <= '0;
      bram_addra_q   <= '0;
      bram_en_q      <= 1'b0;
      load_done_q    <= 1'b0;
      err_len_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      words_loaded_q <= words_loaded_d;
      bram_din_q     <= bram_din_d;
      bram_addra_q   <= bram_addra_d;
      bram_en_q      <= bram_en_d;
      load_done_q    <= load_done_d;
      err_len_q      <= err_len_d;
    end
  end

  assign bram_din     = bram_din_q;
  assign bram_ena     = bram_en_q;
  assign bram_wea     = bram_en_q;
  assign bram_addra   = bram_addra_q;
  assign load_done    = load_done_q;
  assign err_len      = err_len_q;
  assign words_loaded = words_loaded_q;
  assign busy         = (state_q == ST_LOAD) || (state_q == ST_FLUSH);

endmodule

// File: tb/tb_gat_bram_loader.sv
// ---------------------------------------------------------------------------
// tb_gat_bram_loader
//
// Directed bench for gat_bram_loader with a small DEPTH so the oversize case
// runs quickly. Expected BRAM writes are queued as beats are driven and
// popped by a monitor whenever the DUT strobes bram_ena.
// ---------------------------------------------------------------------------
module tb_gat_bram_loader;

  localparam int DEPTH  = 20;
  localparam int ADDR_W = $clog2(DEPTH) + 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [CNT_W-1:0]  len;
  logic [31:0]       s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic              s_tlast;
  logic [31:0]       bram_din;
  logic              bram_ena;
  logic              bram_wea;
  logic [ADDR_W-1:0] bram_addra;
  logic              load_done;
  logic              busy;
  logic              err_len;
  logic [CNT_W-1:0]  words_loaded;

  int total  = 0;
  int bad    = 0;
  int writes = 0;
  int w0;

  logic [ADDR_W+31:0] sb_q[$];

  gat_bram_loader #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .len          (len),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tlast      (s_tlast),
    .bram_din     (bram_din),
    .bram_ena     (bram_ena),
    .bram_wea     (bram_wea),
    .bram_addra   (bram_addra),
    .load_done    (load_done),
    .busy         (busy),
    .err_len      (err_len),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case some wait is never satisfied.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the oldest queued beat.
  always @(negedge clk) begin
    if (rst_n && bram_ena) begin
      logic [ADDR_W+31:0] exp;
      writes++;
      total++;
      assert (sb_q.size() != 0) else begin
        bad++;
        $error("[TB] FAIL sb_underflow observed=%0h expected=queued", {bram_addra, bram_din});
      end
      if (sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        checkOutput("write", 64'({bram_wea, bram_addra, bram_din}), 64'({1'b1, exp}));
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] data, input logic last, input int idx);
    int n = 0;
    @(negedge clk);
    s_tdata  = data;
    s_tlast  = last;
    s_tvalid = 1'b1;
    while (!s_tready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tready_beat", 64'(s_tready), 64'd1);
    sb_q.push_back({ADDR_W'(idx * 4), data});
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic startLoad(input int l);
    @(negedge clk);
    start = 1'b1;
    len   = CNT_W'(l);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic stallCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      checkOutput("tready_stall", 64'(s_tready), 64'd1);
    end
  endtask

  task automatic waitDone(input string tag);
    int n = 0;
    while (!load_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_done"}, 64'(load_done), 64'd1);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_tready"}, 64'(s_tready), 64'd0);
    checkOutput({tag, "_ena"},    64'(bram_ena), 64'd0);
    checkOutput({tag, "_wea"},    64'(bram_wea), 64'd0);
    checkOutput({tag, "_done"},   64'(load_done), 64'd0);
    checkOutput({tag, "_busy"},   64'(busy), 64'd0);
    checkOutput({tag, "_err"},    64'(err_len), 64'd0);
    checkOutput({tag, "_din"},    64'(bram_din), 64'd0);
    checkOutput({tag, "_addra"},  64'(bram_addra), 64'd0);
    checkOutput({tag, "_words"},  64'(words_loaded), 64'd0);
  endtask

  initial begin
    rst_n    = 1'b1;
    start    = 1'b0;
    len      = '0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkReset("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Clean load of four words with tlast on the last one.
    $display("[TB] clean load");
    w0 = writes;
    startLoad(4);
    checkOutput("clean_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) applyStimulus(32'hA0 + 32'(i), i == 3, i);
    @(negedge clk);
    checkOutput("clean_flush_done", 64'(load_done), 64'd0);
    checkOutput("clean_flush_tready", 64'(s_tready), 64'd0);
    checkOutput("clean_flush_busy", 64'(busy), 64'd1);
    @(negedge clk);
    checkOutput("clean_done", 64'(load_done), 64'd1);
    checkOutput("clean_busy_end", 64'(busy), 64'd0);
    checkOutput("clean_err", 64'(err_len), 64'd0);
    checkOutput("clean_words", 64'(words_loaded), 64'd4);
    checkOutput("clean_writes", 64'(writes - w0), 64'd4);
    checkOutput("clean_sb", 64'(sb_q.size()), 64'd0);

    // Stream with valid gaps 1,0,0,1,0,1.
    $display("[TB] stall");
    w0 = writes;
    startLoad(3);
    applyStimulus(32'h1111_0000, 1'b0, 0);
    stallCycles(2);
    applyStimulus(32'h1111_0001, 1'b0, 1);
    stallCycles(1);
    applyStimulus(32'h1111_0002, 1'b1, 2);
    waitDone("stall");
    checkOutput("stall_err", 64'(err_len), 64'd0);
    checkOutput("stall_words", 64'(words_loaded), 64'd3);
    checkOutput("stall_writes", 64'(writes - w0), 64'd3);

    // tlast arrives on word 2 of 5: truncate and flag.
    $display("[TB] early tlast");
    w0 = writes;
    startLoad(5);
    applyStimulus(32'hC0, 1'b0, 0);
    applyStimulus(32'hC1, 1'b1, 1);
    @(negedge clk);
    checkOutput("early_tready", 64'(s_tready), 64'd0);
    waitDone("early");
    checkOutput("early_err", 64'(err_len), 64'd1);
    checkOutput("early_words", 64'(words_loaded), 64'd2);
    s_tvalid = 1'b1;
    s_tdata  = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    checkOutput("early_tready_after", 64'(s_tready), 64'd0);
    s_tvalid = 1'b0;
    checkOutput("early_writes", 64'(writes - w0), 64'd2);

    // Count reached without tlast.
    $display("[TB] missing tlast");
    w0 = writes;
    startLoad(3);
    checkOutput("notlast_err_start", 64'(err_len), 64'd0);
    for (int i = 0; i < 3; i++) applyStimulus(32'h5500 + 32'(i), 1'b0, i);
    waitDone("notlast");
    checkOutput("notlast_err", 64'(err_len), 64'd1);
    checkOutput("notlast_words", 64'(words_loaded), 64'd3);
    checkOutput("notlast_writes", 64'(writes - w0), 64'd3);

    // Oversize request is clamped to DEPTH words.
    $display("[TB] oversize");
    w0 = writes;
    startLoad(DEPTH + 7);
    checkOutput("over_err_start", 64'(err_len), 64'd1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(32'h7700 + 32'(i), 1'b0, i);
    waitDone("over");
    checkOutput("over_err", 64'(err_len), 64'd1);
    checkOutput("over_words", 64'(words_loaded), 64'(DEPTH));
    checkOutput("over_last_addra", 64'(bram_addra), 64'((DEPTH - 1) * 4));
    checkOutput("over_writes", 64'(writes - w0), 64'(DEPTH));

    // Zero length completes with no write.
    $display("[TB] zero length and restart");
    w0 = writes;
    startLoad(0);
    checkOutput("zero_busy", 64'(busy), 64'd0);
    waitDone("zero");
    checkOutput("zero_err", 64'(err_len), 64'd0);
    checkOutput("zero_words", 64'(words_loaded), 64'd0);
    checkOutput("zero_writes", 64'(writes - w0), 64'd0);

    // Restart with len=2; a start pulse mid-load must be ignored.
    startLoad(2);
    checkOutput("restart_done_low", 64'(load_done), 64'd0);
    checkOutput("restart_busy", 64'(busy), 64'd1);
    applyStimulus(32'hB0, 1'b0, 0);
    @(negedge clk);
    start = 1'b1;
    len   = CNT_W'(7);
    @(negedge clk);
    start = 1'b0;
    checkOutput("ignore_tready", 64'(s_tready), 64'd1);
    checkOutput("ignore_words", 64'(words_loaded), 64'd1);
    applyStimulus(32'hB1, 1'b1, 1);
    waitDone("restart");
    checkOutput("restart_words", 64'(words_loaded), 64'd2);
    checkOutput("restart_err", 64'(err_len), 64'd0);
    checkOutput("restart_writes", 64'(writes - w0), 64'd2);

    // Reset after 2 of 6 words, then a full reload from address 0.
    $display("[TB] reset mid-load");
    startLoad(6);
    applyStimulus(32'hE0, 1'b0, 0);
    applyStimulus(32'hE1, 1'b0, 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 checkReset("midreset");
    checkOutput("midreset_sb", 64'(sb_q.size()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    w0 = writes;
    startLoad(6);
    for (int i = 0; i < 6; i++) applyStimulus(32'hF0 + 32'(i), i == 5, i);
    waitDone("reload");
    checkOutput("reload_words", 64'(words_loaded), 64'd6);
    checkOutput("reload_err", 64'(err_len), 64'd0);
    checkOutput("reload_last_addra", 64'(bram_addra), 64'd20);
    checkOutput("reload_writes", 64'(writes - w0), 64'd6);
    checkOutput("final_sb", 64'(sb_q.size()), 64'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gat_bram_loader.md
Name: gat_bram_loader

Overview:
Upstream load stage for the GAT accelerator input BRAMs (H data, H node-info, weight). It accepts a 32-bit valid/ready word stream from the DMA side and drives one BRAM port A with byte addresses stepping by 4 (word index in bits [ADDR_W-1:2]). After the last write it raises the matching *_bram_load_done level. One instance is used per input BRAM.

Parameters:
DEPTH, 242101, maximum words the target BRAM holds
ADDR_W, $clog2(DEPTH)+2 (20 at default), byte-address width of bram_addra
CNT_W, $clog2(DEPTH+1) (18 at default), width of word counters and len

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a load of len words
len  in  CNT_W  words expected; sampled when start is accepted
s_tdata  in  32  stream word
s_tvalid  in  1  stream word valid
s_tready  out  1  loader accepts a word this cycle
s_tlast  in  1  marks the final stream word
bram_din  out  32  BRAM write data
bram_ena  out  1  BRAM port enable
bram_wea  out  1  BRAM write enable
bram_addra  out  ADDR_W  byte address = word_index*4
load_done  out  1  level; all words written, held until next accepted start
busy  out  1  high in LOAD or FLUSH
err_len  out  1  sticky length/tlast mismatch flag, cleared by next accepted start
words_loaded  out  CNT_W  words written in the current/last load

Behaviour:
- Reset (async assert, sync release): state=IDLE; s_tready, bram_ena, bram_wea, load_done, busy, err_len = 0; bram_din, bram_addra, words_loaded = 0.
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE/DONE: s_tready=0. start accepted here -> len_q=min(len,DEPTH); err_len=1 if len>DEPTH else 0; load_done=0; words_loaded=0; cnt=0.
  - If len==0: next state DONE with load_done=1 on the following cycle; no write is issued.
  - Otherwise: next state LOAD.
- start while in LOAD or FLUSH is ignored.
- LOAD: s_tready=1 (combinational from state). A beat is accepted when s_tvalid && s_tready.
- Write pipeline for each accepted beat at cycle T: at T+1, bram_ena=bram_wea=1, bram_din=s_tdata, bram_addra={cnt,2'b00} truncated to ADDR_W. cnt and words_loaded increment at T+1. In all other cycles bram_ena=bram_wea=0; din and addra hold their last values.
- Final beat is the beat with cnt==len_q-1, or any beat with s_tlast=1.
  - If the counts match and s_tlast=1: clean completion.
  - If the counts match and s_tlast=0: err_len=1.
  - If s_tlast=1 before the count is reached: err_len=1 and the load truncates.
  - In all three cases state goes LOAD->FLUSH at T+1. s_tready drops at T+1, so no extra beat is taken.
- FLUSH (one cycle, carries the final write strobe) -> DONE. load_done=1 from T+2 and is held.
- busy = (state==LOAD || state==FLUSH).
- Words arriving while s_tready=0 are not consumed (stream stalls). No backpressure bubbles: one word per cycle throughput in LOAD.
- Address never wraps: len_q<=DEPTH bounds cnt, so the max address is (DEPTH-1)*4.
- rst_n asserted mid-load: immediate return to reset values. Partial BRAM contents are not cleared, and load_done stays 0.

Test Plan:
- Clean load: start, len=4, words 0xA0..0xA3 back-to-back with tlast on the 4th -> writes at addra 0,4,8,12; load_done=1 two cycles after the 4th beat; err_len=0; words_loaded=4.
- Stall: len=3 with s_tvalid gaps (1,0,0,1,0,1) -> exactly 3 writes at addra 0,4,8 with correct data; s_tready high throughout LOAD.
- Early tlast: len=5, tlast on the 2nd word -> 2 writes, load_done=1, err_len=1, words_loaded=2, s_tready=0 afterwards.
- Missing tlast and oversize: len=3 without tlast -> done after 3 writes with err_len=1. Separately, len=DEPTH+7 -> err_len=1 at start and last addra=(DEPTH-1)*4.
- Zero length and restart: len=0 -> load_done=1 with no bram_ena. Then start len=2 -> load_done drops, 2 writes occur, load_done rises again. A start pulse during LOAD is ignored.
- Reset mid-load: rst_n low after 2 of 6 words -> all outputs 0 immediately; a subsequent start with len=6 loads from addra 0.
